// File: rtl/spipoti_rx_pkg.sv
// Shared types and helpers for the digipot SPI target receiver.
// Provides the FSM state encoding, the default accepted command and the frame length rule.
package spipoti_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic [7:0] DEFAULT_CMD = 8'd0;

   function automatic int frame_len(input int width);
      return 8 + width;
   endfunction

endpackage

// File: rtl/spipoti_rx_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, with a history flop for edge detection.
// Flops clear to 0 so a pin already high at reset release only produces a harmless rise.
module spipoti_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic lvl,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_r;
   logic              prev_r;

   // synchroniser chain plus previous-sample flop
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_r <= {STAGES{1'b0}};
         prev_r <= 1'b0;
      end else begin
         sync_r <= {sync_r[STAGES-2:0], din};
         prev_r <= sync_r[STAGES-1];
      end
   end

   assign lvl  = sync_r[STAGES-1];
   assign rise = sync_r[STAGES-1] & ~prev_r;
   assign fall = ~sync_r[STAGES-1] & prev_r;

endmodule

// File: rtl/spipoti_rx.sv
// SPI target for the digipot command+value write frame; oversamples the SPI pins on clk.
// Optional readback of {last_cmd, value} on miso when SPIPOTI_RX_MISO_EN is defined.
module spipoti_rx
   import spipoti_pkg::*;
#(
   parameter int               WIDTH       = 8,
   parameter logic [7:0]       CMD         = DEFAULT_CMD,
   parameter int               SYNC_STAGES = 2,
   parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sclk,
   input  logic             mosi,
   input  logic             sel,
   output logic             miso,
   output logic [WIDTH-1:0] value,
   output logic [7:0]       last_cmd,
   output logic             valid,
   output logic             cmd_err,
   output logic             frame_err
);

   localparam int FRAME = frame_len(WIDTH);
   localparam int CW    = $clog2(FRAME + 2);
   localparam logic [CW-1:0] CNT_FRAME = CW'(FRAME);
   localparam logic [CW-1:0] CNT_SAT   = CW'(FRAME + 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   state_t           state_r;
   logic [CW-1:0]    bit_cnt_r;
   logic [FRAME-1:0] shift_r;

   logic sclk_lvl_s, sclk_rise_s, sclk_fall_s;
   logic mosi_lvl_s, mosi_rise_s, mosi_fall_s;
   logic sel_lvl_s, sel_rise_s, sel_fall_s;
   logic unused_s;

   spipoti_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
      .clk(clk), .rst(rst), .din(sclk), .lvl(sclk_lvl_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
   );
   spipoti_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
      .clk(clk), .rst(rst), .din(mosi), .lvl(mosi_lvl_s), .rise(mosi_rise_s), .fall(mosi_fall_s)
   );
   spipoti_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sel (
      .clk(clk), .rst(rst), .din(sel), .lvl(sel_lvl_s), .rise(sel_rise_s), .fall(sel_fall_s)
   );

   assign unused_s = ^{sclk_lvl_s, sclk_fall_s, mosi_rise_s, mosi_fall_s};

   // frame FSM: sel_rise wins over a coincident sclk_rise, so that edge is never counted
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         bit_cnt_r <= {CW{1'b0}};
         shift_r   <= {FRAME{1'b0}};
         value     <= RESET_VALUE;
         last_cmd  <= 8'd0;
         valid     <= 1'b0;
         cmd_err   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         valid     <= 1'b0;
         cmd_err   <= 1'b0;
         frame_err <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (sel_fall_s) begin
                  bit_cnt_r <= {CW{1'b0}};
                  shift_r   <= {FRAME{1'b0}};
                  state_r   <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (sel_rise_s) begin
                  state_r <= ST_DONE;
               end else if (sclk_rise_s && !sel_lvl_s) begin
                  shift_r <= {shift_r[FRAME-2:0], mosi_lvl_s};
                  if (bit_cnt_r != CNT_SAT) begin
                     bit_cnt_r <= bit_cnt_r + CNT_ONE;
                  end
               end
            end
            ST_DONE: begin
               if (bit_cnt_r != CNT_FRAME) begin
                  frame_err <= 1'b1;
               end else begin
                  last_cmd <= shift_r[FRAME-1:WIDTH];
                  if (shift_r[FRAME-1:WIDTH] == CMD) begin
                     value <= shift_r[WIDTH-1:0];
                     valid <= 1'b1;
                  end else begin
                     cmd_err <= 1'b1;
                  end
               end
               state_r <= ST_IDLE;
            end
            default: state_r <= ST_IDLE;
         endcase
      end
   end

`ifdef SPIPOTI_RX_MISO_EN
   logic [FRAME-1:0] out_r;

   // readback register: snapshot of the previous state, shifted after each sampled bit
   always_ff @(posedge clk) begin
      if (rst) begin
         out_r <= {FRAME{1'b0}};
         miso  <= 1'b0;
      end else begin
         if (sel_fall_s) begin
            out_r <= {last_cmd, value};
         end else if (sclk_rise_s && !sel_lvl_s && state_r == ST_SHIFT) begin
            out_r <= {out_r[FRAME-2:0], 1'b0};
         end
         miso <= out_r[FRAME-1] & ~sel_lvl_s;
      end
   end
`else
   // no readback path: miso held low
   always_ff @(posedge clk) begin
      miso <= 1'b0;
   end
`endif

endmodule

// File: tb/tb_spipoti_rx.sv
// Randomised self-checking bench for spipoti_rx against a frame-level reference model.
// Checks miso readback when SPIPOTI_RX_MISO_EN is defined, otherwise that miso stays 0.
module tb_spipoti_rx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sclk = 1'b0;
   logic       mosi = 1'b0;
   logic       sel = 1'b1;
   logic       miso;
   logic [7:0] value;
   logic [7:0] last_cmd;
   logic       valid, cmd_err, frame_err;

   int checks = 0;
   int errors = 0;
   int tot_v = 0, tot_c = 0, tot_f = 0;

   logic [7:0] model_value = 8'h00;
   logic [7:0] model_last  = 8'h00;

   spipoti_rx dut (
      .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .sel(sel), .miso(miso),
      .value(value), .last_cmd(last_cmd), .valid(valid), .cmd_err(cmd_err), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   // count high cycles of each status pulse
   always @(negedge clk) begin
      if (valid === 1'b1) tot_v++;
      if (cmd_err === 1'b1) tot_c++;
      if (frame_err === 1'b1) tot_f++;
   end

   // reference: what a complete frame of nbits should do to the pot
   task automatic model_frame(input logic [23:0] word, input int nbits,
                              output int ev, output int ec, output int ef);
      ev = 0; ec = 0; ef = 0;
      if (nbits != 16) begin
         ef = 1;
      end else begin
         model_last = word[15:8];
         if (word[15:8] == 8'h00) begin
            model_value = word[7:0];
            ev = 1;
         end else begin
            ec = 1;
         end
      end
   endtask

   // drive one frame at clk/8; optional reset pulse after bit rst_after, optional sclk edge on sel_fall
   task automatic send_frame(input logic [23:0] word, input int nbits, input int rst_after,
                             input bit align_edge, output int dv, output int dc, output int df);
      logic [15:0] rb;
      logic        exp_miso;
      int          v0, c0, f0;
      rb = {model_last, model_value};
      v0 = tot_v; c0 = tot_c; f0 = tot_f;
      @(negedge clk);
      sel = 1'b0;
      if (align_edge) sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         mosi = word[nbits-1-i];
         repeat (4) @(negedge clk);
         if (rst_after < 0) begin
`ifdef SPIPOTI_RX_MISO_EN
            exp_miso = (i < 16) ? rb[15-i] : 1'b0;
`else
            exp_miso = 1'b0;
`endif
            checks++;
            if (miso !== exp_miso) begin
               errors++;
               $display("FAIL miso bit %0d: got %b expected %b", i, miso, exp_miso);
            end
         end
         sclk = 1'b1;
         repeat (4) @(negedge clk);
         sclk = 1'b0;
         if (i + 1 == rst_after) begin
            rst = 1'b1;
            repeat (2) @(negedge clk);
            rst = 1'b0;
         end
      end
      repeat (4) @(negedge clk);
      sel = 1'b1;
      repeat (12) @(negedge clk);
      dv = tot_v - v0; dc = tot_c - c0; df = tot_f - f0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (4) @(negedge clk);
      checks += 5;
      if (value !== 8'h00) begin errors++; $display("FAIL reset value: got %h expected 00", value); end
      if (last_cmd !== 8'h00) begin errors++; $display("FAIL reset last_cmd: got %h expected 00", last_cmd); end
      if (valid !== 1'b0) begin errors++; $display("FAIL reset valid: got %b expected 0", valid); end
      if ({cmd_err, frame_err} !== 2'b00) begin errors++; $display("FAIL reset errs: got %b expected 00", {cmd_err, frame_err}); end
      if (miso !== 1'b0) begin errors++; $display("FAIL reset miso: got %b expected 0", miso); end
      rst = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_decode();
      logic [23:0] words [4] = '{24'h0000A5, 24'h00113C, 24'h000ABC, 24'h015AA5};
      int          lens  [4] = '{16, 16, 12, 17};
      int dv, dc, df, ev, ec, ef;
      for (int k = 0; k < 4; k++) begin
         send_frame(words[k], lens[k], -1, 1'b0, dv, dc, df);
         model_frame(words[k], lens[k], ev, ec, ef);
         checks += 5;
         if (dv != ev) begin errors++; $display("FAIL decode%0d valid pulses: got %0d expected %0d", k, dv, ev); end
         if (dc != ec) begin errors++; $display("FAIL decode%0d cmd_err pulses: got %0d expected %0d", k, dc, ec); end
         if (df != ef) begin errors++; $display("FAIL decode%0d frame_err pulses: got %0d expected %0d", k, df, ef); end
         if (value !== model_value) begin errors++; $display("FAIL decode%0d value: got %h expected %h", k, value, model_value); end
         if (last_cmd !== model_last) begin errors++; $display("FAIL decode%0d last_cmd: got %h expected %h", k, last_cmd, model_last); end
      end
   endtask

   task automatic test_rst_mid();
      int dv, dc, df, ev, ec, ef;
      send_frame(24'h00005A, 16, 7, 1'b0, dv, dc, df);
      model_value = 8'h00;
      model_last  = 8'h00;
      checks += 4;
      if (dv + dc + df != 0) begin errors++; $display("FAIL rst_mid pulses: got %0d expected 0", dv + dc + df); end
      if (value !== 8'h00) begin errors++; $display("FAIL rst_mid value: got %h expected 00", value); end
      if (last_cmd !== 8'h00) begin errors++; $display("FAIL rst_mid last_cmd: got %h expected 00", last_cmd); end
      send_frame(24'h00000F, 16, -1, 1'b0, dv, dc, df);
      model_frame(24'h00000F, 16, ev, ec, ef);
      if (value !== model_value || dv != ev) begin
         errors++;
         $display("FAIL rst_mid clean frame: got value %h valid %0d expected %h %0d", value, dv, model_value, ev);
      end
   endtask

   task automatic test_ignored_edges();
      int dv, dc, df, ev, ec, ef, v0, c0, f0;
      v0 = tot_v; c0 = tot_c; f0 = tot_f;
      for (int i = 0; i < 5; i++) begin
         mosi = i[0];
         sclk = 1'b1; repeat (4) @(negedge clk);
         sclk = 1'b0; repeat (4) @(negedge clk);
      end
      checks += 2;
      if ((tot_v - v0) + (tot_c - c0) + (tot_f - f0) != 0) begin
         errors++; $display("FAIL idle_sclk pulses: got %0d expected 0", (tot_v - v0) + (tot_c - c0) + (tot_f - f0));
      end
      if (value !== model_value) begin errors++; $display("FAIL idle_sclk value: got %h expected %h", value, model_value); end
      send_frame(24'h000080, 16, -1, 1'b1, dv, dc, df);
      model_frame(24'h000080, 16, ev, ec, ef);
      checks += 3;
      if (dv != ev) begin errors++; $display("FAIL aligned valid pulses: got %0d expected %0d", dv, ev); end
      if (dc + df != ec + ef) begin errors++; $display("FAIL aligned err pulses: got %0d expected %0d", dc + df, ec + ef); end
      if (value !== model_value) begin errors++; $display("FAIL aligned value: got %h expected %h", value, model_value); end
   endtask

   task automatic test_random();
      logic [23:0] word;
      int nbits, dv, dc, df, ev, ec, ef;
      for (int k = 0; k < 10; k++) begin
         word = 24'($urandom);
         if ($urandom_range(1, 0) == 0) word[15:8] = 8'h00;
         nbits = ($urandom_range(3, 0) == 0) ? int'($urandom_range(18, 13)) : 16;
         send_frame(word, nbits, -1, 1'b0, dv, dc, df);
         model_frame(word, nbits, ev, ec, ef);
         checks += 5;
         if (dv != ev) begin errors++; $display("FAIL rand%0d valid pulses: got %0d expected %0d", k, dv, ev); end
         if (dc != ec) begin errors++; $display("FAIL rand%0d cmd_err pulses: got %0d expected %0d", k, dc, ec); end
         if (df != ef) begin errors++; $display("FAIL rand%0d frame_err pulses: got %0d expected %0d", k, df, ef); end
         if (value !== model_value) begin errors++; $display("FAIL rand%0d value: got %h expected %h", k, value, model_value); end
         if (last_cmd !== model_last) begin errors++; $display("FAIL rand%0d last_cmd: got %h expected %h", k, last_cmd, model_last); end
      end
   endtask

   initial begin
      test_reset();
      test_decode();
      test_rst_mid();
      test_ignored_edges();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
